// File: rtl/accum_16bit_if.sv
// Handshake bundle for accum_16bit: sample input stream and batch result output.
interface accum_16bit_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic        out_carry;
  logic [7:0]  out_count;

  // Producer/consumer side: drives samples and accepts results.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sum, out_carry, out_count
  );

  // Accumulator side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sum, out_carry, out_count
  );
endinterface

// File: rtl/accum_16bit.sv
// Batch accumulator: sums NUM_SAMPLES 16-bit samples through a ripple adder and
// holds each batch total (with a sticky carry) until downstream takes it.

// 16-bit ripple-carry adder.
module adder_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        c_in,
  output logic [15:0] sum,
  output logic        c_out
);
  logic carry;

  // Ripple the carry bit by bit from LSB to MSB.
  always_comb begin
    carry = c_in;
    sum   = '0;
    for (int i = 0; i < 16; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    c_out = carry;
  end
endmodule

module accum_16bit #(
  parameter int NUM_SAMPLES = 8,   // samples per batch, 1..255
  parameter bit SAT         = 1'b0 // 1: clamp accumulator at 16'hFFFF after a carry
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  accum_16bit_if.slave  bus
);
  typedef enum logic {ACC, HOLD} state_t;

  localparam logic [7:0] LAST_CNT = 8'(NUM_SAMPLES - 1);

  state_t      state_q, state_d;
  logic [15:0] acc_q, acc_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        sticky_q, sticky_d;

  logic [15:0] add_sum;
  logic        add_co;
  logic        accept;

  adder_16bit u_adder (
    .a     (acc_q),
    .b     (bus.in_data),
    .c_in  (1'b0),
    .sum   (add_sum),
    .c_out (add_co)
  );

  // Handshake flags come from the state register only, so there is no
  // combinational path from in_valid or out_ready.
  assign bus.in_ready  = (state_q == ACC);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_sum   = acc_q;
  assign bus.out_carry = sticky_q;
  assign bus.out_count = cnt_q;
  assign accept        = bus.in_valid & bus.in_ready;

  // Next-state logic: clr aborts, accepts accumulate, a taken result restarts.
  always_comb begin
    // NOTE: every signal gets a default first so no branch can infer a latch.
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;

    if (clr) begin
      state_d  = ACC;
      acc_d    = '0;
      cnt_d    = '0;
      sticky_d = 1'b0;
    end else if (state_q == ACC) begin
      if (accept) begin
        acc_d    = (SAT && (add_co || sticky_q)) ? 16'hFFFF : add_sum;
        sticky_d = sticky_q | add_co;
        cnt_d    = cnt_q + 8'd1;
        if (cnt_q == LAST_CNT) state_d = HOLD;
      end
    end else if (bus.out_ready) begin
      state_d  = ACC;
      acc_d    = '0;
      cnt_d    = '0;
      sticky_d = 1'b0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking so all registers update together from pre-edge values.
    if (rst) begin
      state_q  <= ACC;
      acc_q    <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
    end
  end
endmodule

// File: tb/tb_accum_16bit.sv
// Self-checking bench for accum_16bit: three configurations driven in lockstep
// and compared every cycle against a batch-level arithmetic model.
module tb_accum_16bit;
  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_ready;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  accum_16bit_if if_w ();
  accum_16bit_if if_s ();
  accum_16bit_if if_o ();

  assign if_w.in_valid = in_valid;  assign if_w.in_data = in_data;  assign if_w.out_ready = out_ready;
  assign if_s.in_valid = in_valid;  assign if_s.in_data = in_data;  assign if_s.out_ready = out_ready;
  assign if_o.in_valid = in_valid;  assign if_o.in_data = in_data;  assign if_o.out_ready = out_ready;

  accum_16bit #(.NUM_SAMPLES(4), .SAT(1'b0)) u_wrap (.clk(clk), .rst(rst), .clr(clr), .bus(if_w));
  accum_16bit #(.NUM_SAMPLES(4), .SAT(1'b1)) u_sat  (.clk(clk), .rst(rst), .clr(clr), .bus(if_s));
  accum_16bit #(.NUM_SAMPLES(1), .SAT(1'b0)) u_one  (.clk(clk), .rst(rst), .clr(clr), .bus(if_o));

  // Reference model: per configuration, the batch is a running integer total
  // plus a sample count; wrap/saturate/carry are derived from the true total.
  int m_n     [3] = '{4, 4, 1};
  bit m_sat   [3] = '{1'b0, 1'b1, 1'b0};
  int m_total [3] = '{0, 0, 0};
  int m_cnt   [3] = '{0, 0, 0};
  bit m_hold  [3] = '{1'b0, 1'b0, 1'b0};

  function automatic logic [15:0] exp_sum(int i);
    if (m_sat[i] && m_total[i] >= 65536) return 16'hFFFF;
    return 16'(m_total[i] % 65536);
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst || clr) begin
        m_total[i] = 0; m_cnt[i] = 0; m_hold[i] = 1'b0;
      end else if (!m_hold[i]) begin
        if (in_valid) begin
          m_total[i] = m_total[i] + int'(in_data);
          m_cnt[i]   = m_cnt[i] + 1;
          if (m_cnt[i] == m_n[i]) m_hold[i] = 1'b1;
        end
      end else if (out_ready) begin
        m_total[i] = 0; m_cnt[i] = 0; m_hold[i] = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_inst(input string name, input int i, input logic rdy, input logic vld,
                            input logic [15:0] sum, input logic carry, input logic [7:0] cnt);
    check({name, ".in_ready"},  32'(rdy),   32'(!m_hold[i]));
    check({name, ".out_valid"}, 32'(vld),   32'(m_hold[i]));
    check({name, ".out_sum"},   32'(sum),   32'(exp_sum(i)));
    check({name, ".out_carry"}, 32'(carry), 32'(m_total[i] >= 65536));
    check({name, ".out_count"}, 32'(cnt),   32'(m_cnt[i]));
  endtask

  // Outputs change only at posedge, so the falling edge is a stable sample point.
  always @(negedge clk) begin
    if (chk_en) begin
      check_inst("wrap", 0, if_w.in_ready, if_w.out_valid, if_w.out_sum, if_w.out_carry, if_w.out_count);
      check_inst("sat",  1, if_s.in_ready, if_s.out_valid, if_s.out_sum, if_s.out_carry, if_s.out_count);
      check_inst("one",  2, if_o.in_ready, if_o.out_valid, if_o.out_sum, if_o.out_carry, if_o.out_count);
    end
  end

  // Apply inputs at a falling edge, return at the next falling edge.
  task automatic tick(input bit v, input logic [15:0] d, input bit r, input bit c);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    clr       = c;
    @(negedge clk);
  endtask

  initial begin
    int exp_cnt;
    bit gap_v [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    rst = 1'b0;

    // Reset state.
    check("rst_in_ready",  32'(if_w.in_ready),  32'd1);
    check("rst_out_valid", 32'(if_w.out_valid), 32'd0);
    check("rst_out_sum",   32'(if_w.out_sum),   32'd0);
    check("rst_out_count", 32'(if_w.out_count), 32'd0);

    // Basic batch 1+2+3+4.
    for (int k = 1; k <= 4; k++) tick(1'b1, 16'(k), 1'b1, 1'b0);
    check("basic_valid", 32'(if_w.out_valid), 32'd1);
    check("basic_sum",   32'(if_w.out_sum),   32'd10);
    check("basic_carry", 32'(if_w.out_carry), 32'd0);
    check("basic_count", 32'(if_w.out_count), 32'd4);
    tick(1'b0, 16'h0, 1'b1, 1'b0);
    check("basic_ready_again", 32'(if_w.in_ready), 32'd1);

    // Wrap: FFF0 + 0020 + 0 + 0.
    tick(1'b1, 16'hFFF0, 1'b1, 1'b0);
    tick(1'b1, 16'h0020, 1'b1, 1'b0);
    tick(1'b1, 16'h0000, 1'b1, 1'b0);
    tick(1'b1, 16'h0000, 1'b1, 1'b0);
    check("wrap_sum",   32'(if_w.out_sum),   32'h0010);
    check("wrap_carry", 32'(if_w.out_carry), 32'd1);
    tick(1'b0, 16'h0, 1'b1, 1'b0);

    // Saturate: FFF0 + 0020 + 0001 + 0.
    tick(1'b1, 16'hFFF0, 1'b1, 1'b0);
    tick(1'b1, 16'h0020, 1'b1, 1'b0);
    tick(1'b1, 16'h0001, 1'b1, 1'b0);
    tick(1'b1, 16'h0000, 1'b1, 1'b0);
    check("sat_sum",      32'(if_s.out_sum),   32'hFFFF);
    check("sat_carry",    32'(if_s.out_carry), 32'd1);
    check("sat_wrap_sum", 32'(if_w.out_sum),   32'h0011);
    tick(1'b0, 16'h0, 1'b1, 1'b0);

    // Backpressure with in_valid held high and data 7.
    for (int k = 0; k < 4; k++) tick(1'b1, 16'h1, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      tick(1'b1, 16'h7, 1'b0, 1'b0);
      check("bp_in_ready", 32'(if_w.in_ready), 32'd0);
      check("bp_hold_sum", 32'(if_w.out_sum),  32'd4);
    end
    tick(1'b1, 16'h7, 1'b1, 1'b0);
    check("bp_restart_count", 32'(if_w.out_count), 32'd0);
    check("bp_restart_sum",   32'(if_w.out_sum),   32'd0);
    tick(1'b1, 16'h7, 1'b1, 1'b0);
    check("bp_first_sum", 32'(if_w.out_sum), 32'd7);
    for (int k = 0; k < 3; k++) tick(1'b1, 16'h0, 1'b1, 1'b0);
    check("bp_batch_sum", 32'(if_w.out_sum), 32'd7);
    tick(1'b0, 16'h0, 1'b1, 1'b0);

    // Gapped input.
    exp_cnt = 0;
    for (int k = 0; k < 7; k++) begin
      tick(gap_v[k], 16'h5, 1'b0, 1'b0);
      exp_cnt += int'(gap_v[k]);
      check("gap_count", 32'(if_w.out_count), 32'(exp_cnt));
    end
    check("gap_sum", 32'(if_w.out_sum), 32'd20);
    tick(1'b0, 16'h0, 1'b1, 1'b0);

    // Abort mid-batch; the sample offered with clr is dropped.
    tick(1'b1, 16'h3, 1'b0, 1'b0);
    tick(1'b1, 16'h3, 1'b0, 1'b0);
    tick(1'b1, 16'h9, 1'b0, 1'b1);
    check("clr_count", 32'(if_w.out_count), 32'd0);
    check("clr_sum",   32'(if_w.out_sum),   32'd0);
    for (int k = 0; k < 4; k++) tick(1'b1, 16'h1, 1'b0, 1'b0);
    check("clr_batch_sum",   32'(if_w.out_sum),   32'd4);
    check("clr_batch_carry", 32'(if_w.out_carry), 32'd0);
    rst = 1'b1;
    tick(1'b0, 16'h0, 1'b0, 1'b0);
    rst = 1'b0;
    check("rst_hold_valid", 32'(if_w.out_valid), 32'd0);
    check("rst_hold_count", 32'(if_w.out_count), 32'd0);

    // Randomized traffic, including occasional clr and large samples.
    for (int k = 0; k < 3000; k++) begin
      logic [15:0] d;
      d = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
      tick($urandom_range(0, 9) < 7, d, $urandom_range(0, 1) == 1, $urandom_range(0, 49) == 0);
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
